fix_checksum_checker: RTL and testbench

Streaming checksum engine for received FIX messages, the parametrised successor to the single-byte checksum block. It accepts 1 to 8 message bytes per clock beat. It computes the FIX body checksum: the sum modulo 256 of every byte from `8=` up to and including the SOH that precedes the `10=` trailer. It also parses the three-digit received checksum and reports computed value, received value, ASCII form and a match/format verdict once per message. It sits between the byte-stream deframer and the message dispatcher.

---
 rtl/fix_checksum_checker.sv | 217 +++++++++++++++++++++
 tb/tb_fix_checksum_checker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fix_checksum_checker.sv
// FIX body checksum checker: sums message bytes up to the SOH that opens the
// 10= trailer, parses the received 3-digit value and reports a verdict per message.

package fix_cks_pkg;
    typedef enum logic [3:0] {
        P_START, P_G1, P_G10, P_GEQ, P_D1, P_D2, P_D3, P_DONE, P_OTHER
    } pst_t;
endpackage

// One byte step of the per-beat chain; a skipped lane passes state through.
module fix_cks_lane
    import fix_cks_pkg::*;
#(
    parameter logic [7:0] SOH = 8'h01
) (
    input  logic       i_keep,
    input  logic [7:0] i_byte,
    input  logic [7:0] i_sum,
    input  logic [7:0] i_cand,
    input  logic [7:0] i_pre,
    input  logic       i_pre_ok,
    input  logic       i_soh_seen,
    input  pst_t       i_pst,
    input  logic [9:0] i_rx,
    output logic [7:0] o_sum,
    output logic [7:0] o_cand,
    output logic [7:0] o_pre,
    output logic       o_pre_ok,
    output logic       o_soh_seen,
    output pst_t       o_pst,
    output logic [9:0] o_rx
);
    logic       w_soh;
    logic       w_dig;
    logic [3:0] w_d;
    logic [7:0] w_sum;
    logic [9:0] w_acc;

    assign w_soh = (i_byte == SOH);
    assign w_dig = (i_byte >= 8'h30) && (i_byte <= 8'h39);
    // for ASCII digits the low nibble is exactly byte - 8'h30
    assign w_d   = i_byte[3:0];
    assign w_sum = i_sum + i_byte;
    assign w_acc = i_rx * 10'd10 + {6'd0, w_d};

    always_comb begin
        o_sum      = i_sum;
        o_cand     = i_cand;
        o_pre      = i_pre;
        o_pre_ok   = i_pre_ok;
        o_soh_seen = i_soh_seen;
        o_pst      = i_pst;
        o_rx       = i_rx;
        if (i_keep) begin
            o_sum = w_sum;
            // leaving START: remember the sum at the SOH that opened this field
            if (i_pst == P_START && !w_soh) begin
                o_pre    = i_cand;
                o_pre_ok = i_soh_seen;
            end
            if (w_soh) begin
                o_cand     = w_sum;
                o_soh_seen = 1'b1;
                o_pst      = (i_pst == P_D3) ? P_DONE : P_START;
            end else begin
                o_pst = P_OTHER;
                case (i_pst)
                    P_START: if (i_byte == 8'h31) o_pst = P_G1;
                    P_G1:    if (i_byte == 8'h30) o_pst = P_G10;
                    P_G10:   if (i_byte == 8'h3D) o_pst = P_GEQ;
                    P_GEQ:   if (w_dig) begin o_pst = P_D1; o_rx = {6'd0, w_d}; end
                    P_D1:    if (w_dig) begin o_pst = P_D2; o_rx = w_acc; end
                    P_D2:    if (w_dig) begin o_pst = P_D3; o_rx = w_acc; end
                    default: o_pst = P_OTHER;
                endcase
            end
        end
    end
endmodule

module fix_checksum_checker
    import fix_cks_pkg::*;
#(
    parameter int         LANES = 1,
    parameter logic [7:0] SOH   = 8'h01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [8*LANES-1:0] in_data,
    input  logic [LANES-1:0]   in_keep,
    input  logic               in_sop,
    input  logic               in_eop,
    output logic               out_valid,
    output logic [7:0]         out_sum,
    output logic [23:0]        out_sum_ascii,
    output logic [9:0]         out_rx_sum,
    output logic               out_match,
    output logic               out_fmt_err
);
    typedef enum logic {F_IDLE, F_IN_MSG} fsm_t;

    fsm_t       r_fsm, w_fsm_nxt;
    logic [7:0] r_sum, r_cand, r_pre;
    logic       r_pre_ok, r_soh_seen;
    pst_t       r_pst;
    logic [9:0] r_rx;

    logic        r_out_valid, r_out_match, r_out_fmt;
    logic [7:0]  r_out_sum;
    logic [23:0] r_out_ascii;
    logic [9:0]  r_out_rx;

    logic [LANES:0][7:0] w_sum, w_cand, w_pre;
    logic [LANES:0]      w_pre_ok, w_soh_seen;
    logic [LANES:0][9:0] w_rx;
    pst_t                w_pst [LANES+1];

    logic       w_active, w_fmt;
    logic [1:0] w_hund;
    logic [7:0] w_rem, w_tens, w_unit, w_res_sum;

    assign w_active = in_valid && (in_sop || r_fsm == F_IN_MSG);

    // a sop beat starts from a clean state, also aborting any open message
    assign w_sum[0]      = in_sop ? 8'd0 : r_sum;
    assign w_cand[0]     = in_sop ? 8'd0 : r_cand;
    assign w_pre[0]      = in_sop ? 8'd0 : r_pre;
    assign w_pre_ok[0]   = in_sop ? 1'b0 : r_pre_ok;
    assign w_soh_seen[0] = in_sop ? 1'b0 : r_soh_seen;
    assign w_pst[0]      = in_sop ? P_START : r_pst;
    assign w_rx[0]       = in_sop ? 10'd0 : r_rx;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fix_cks_lane #(.SOH(SOH)) u_lane (
            .i_keep     (in_keep[g]),
            .i_byte     (in_data[8*g +: 8]),
            .i_sum      (w_sum[g]),
            .i_cand     (w_cand[g]),
            .i_pre      (w_pre[g]),
            .i_pre_ok   (w_pre_ok[g]),
            .i_soh_seen (w_soh_seen[g]),
            .i_pst      (w_pst[g]),
            .i_rx       (w_rx[g]),
            .o_sum      (w_sum[g+1]),
            .o_cand     (w_cand[g+1]),
            .o_pre      (w_pre[g+1]),
            .o_pre_ok   (w_pre_ok[g+1]),
            .o_soh_seen (w_soh_seen[g+1]),
            .o_pst      (w_pst[g+1]),
            .o_rx       (w_rx[g+1])
        );
    end

    assign w_res_sum = w_pre[LANES];
    assign w_fmt     = !(w_pst[LANES] == P_DONE && w_pre_ok[LANES]);

    assign w_hund = (w_res_sum >= 8'd200) ? 2'd2 : (w_res_sum >= 8'd100) ? 2'd1 : 2'd0;
    assign w_rem  = w_res_sum - ((w_hund == 2'd2) ? 8'd200 : (w_hund == 2'd1) ? 8'd100 : 8'd0);
    assign w_tens = w_rem / 8'd10;
    assign w_unit = w_rem % 8'd10;

    always_comb begin
        w_fsm_nxt = r_fsm;
        if (w_active)
            w_fsm_nxt = in_eop ? F_IDLE : F_IN_MSG;
    end

    always_ff @(posedge clk) begin
        if (rst) r_fsm <= F_IDLE;
        else     r_fsm <= w_fsm_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= 8'd0;
            r_cand      <= 8'd0;
            r_pre       <= 8'd0;
            r_pre_ok    <= 1'b0;
            r_soh_seen  <= 1'b0;
            r_pst       <= P_START;
            r_rx        <= 10'd0;
            r_out_valid <= 1'b0;
            r_out_sum   <= 8'd0;
            r_out_ascii <= 24'd0;
            r_out_rx    <= 10'd0;
            r_out_match <= 1'b0;
            r_out_fmt   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_active) begin
                r_sum      <= w_sum[LANES];
                r_cand     <= w_cand[LANES];
                r_pre      <= w_pre[LANES];
                r_pre_ok   <= w_pre_ok[LANES];
                r_soh_seen <= w_soh_seen[LANES];
                r_pst      <= w_pst[LANES];
                r_rx       <= w_rx[LANES];
            end
            if (w_active && in_eop) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_res_sum;
                r_out_ascii <= {8'h30 + {6'd0, w_hund}, 8'h30 + w_tens, 8'h30 + w_unit};
                r_out_rx    <= w_rx[LANES];
                r_out_fmt   <= w_fmt;
                r_out_match <= !w_fmt && (w_rx[LANES] == {2'b00, w_res_sum});
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_sum       = r_out_sum;
    assign out_sum_ascii = r_out_ascii;
    assign out_rx_sum    = r_out_rx;
    assign out_match     = r_out_match;
    assign out_fmt_err   = r_out_fmt;
endmodule

// File: tb/tb_fix_checksum_checker.sv
// Scoreboard bench: a LANES=1 and a LANES=4 checker fed FIX messages;
// expected results are queued at the eop beat and checked when out_valid pulses.
module tb_fix_checksum_checker;
    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]  sum;
        logic [23:0] asc;
        logic [9:0]  rx;
        logic        m;
        logic        f;
        logic        chk_rx;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic        v1, sop1, eop1;
    logic [7:0]  d1;
    logic [0:0]  k1;
    logic        o1_valid, o1_match, o1_fmt;
    logic [7:0]  o1_sum;
    logic [23:0] o1_asc;
    logic [9:0]  o1_rx;

    logic        v4, sop4, eop4;
    logic [31:0] d4;
    logic [3:0]  k4;
    logic        o4_valid, o4_match, o4_fmt;
    logic [7:0]  o4_sum;
    logic [23:0] o4_asc;
    logic [9:0]  o4_rx;

    exp_t q1[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fix_checksum_checker #(.LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_keep(k1),
        .in_sop(sop1), .in_eop(eop1), .out_valid(o1_valid), .out_sum(o1_sum),
        .out_sum_ascii(o1_asc), .out_rx_sum(o1_rx), .out_match(o1_match),
        .out_fmt_err(o1_fmt)
    );

    fix_checksum_checker #(.LANES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_keep(k4),
        .in_sop(sop4), .in_eop(eop4), .out_valid(o4_valid), .out_sum(o4_sum),
        .out_sum_ascii(o4_asc), .out_rx_sum(o4_rx), .out_match(o4_match),
        .out_fmt_err(o4_fmt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // '|' stands for SOH
    function automatic bq_t mk(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++)
            q.push_back((s[i] == 8'h7C) ? 8'h01 : s[i]);
        return q;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            v1 = 0; sop1 = 0; eop1 = 0; k1 = 0; d1 = 0;
            v4 = 0; sop4 = 0; eop4 = 0; k4 = 0; d4 = 0;
        end
    endtask

    task automatic send1(input bq_t m, input bit sop, input bit eop, input exp_t e);
        for (int i = 0; i < m.size(); i++) begin
            @(posedge clk); #1;
            v1 = 1; d1 = m[i]; k1 = 1;
            sop1 = sop && (i == 0);
            eop1 = eop && (i == m.size() - 1);
            if (eop1) begin e.cyc = cyc + 1; q1.push_back(e); end
        end
    endtask

    // gap: slot index that becomes a keep=0 lane (-1 for none)
    task automatic send4(input bq_t m, input int gap, input exp_t e);
        int  slot = 0;
        int  idx = 0;
        bit  first = 1;
        logic [31:0] d;
        logic [3:0]  k;
        while (idx < m.size()) begin
            d = 0; k = 0;
            for (int l = 0; l < 4; l++) begin
                if (slot == gap) slot++;
                else if (idx < m.size()) begin
                    d[8*l +: 8] = m[idx]; k[l] = 1'b1; idx++; slot++;
                end
            end
            @(posedge clk); #1;
            v4 = 1; d4 = d; k4 = k; sop4 = first; eop4 = (idx >= m.size()); first = 0;
            if (eop4) begin e.cyc = cyc + 1; q4.push_back(e); end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (o1_valid) begin
            if (q1.size() == 0) check("unexp_out1", 1, 0);
            else begin
                e = q1.pop_front();
                check("lat1", cyc, e.cyc);
                check("sum1", o1_sum, e.sum);
                check("asc1", o1_asc, e.asc);
                check("match1", o1_match, e.m);
                check("fmt1", o1_fmt, e.f);
                if (e.chk_rx) check("rx1", o1_rx, e.rx);
            end
        end
        if (o4_valid) begin
            if (q4.size() == 0) check("unexp_out4", 1, 0);
            else begin
                e = q4.pop_front();
                check("lat4", cyc, e.cyc);
                check("sum4", o4_sum, e.sum);
                check("asc4", o4_asc, e.asc);
                check("match4", o4_match, e.m);
                check("fmt4", o4_fmt, e.f);
                if (e.chk_rx) check("rx4", o4_rx, e.rx);
            end
        end
    end

    initial begin
        exp_t e183, e106, e107, eerr, etr;
        e183 = '{8'hB7, 24'h313833, 10'd183, 1'b1, 1'b0, 1'b1, 0};
        e106 = '{8'd106, 24'h313036, 10'd106, 1'b1, 1'b0, 1'b1, 0};
        e107 = '{8'd106, 24'h313036, 10'd107, 1'b0, 1'b0, 1'b1, 0};
        eerr = '{8'hB7, 24'h313833, 10'd0, 1'b0, 1'b1, 1'b0, 0};
        etr  = '{8'd0, 24'h303030, 10'd183, 1'b0, 1'b1, 1'b1, 0};

        rst = 1;
        v1 = 0; sop1 = 0; eop1 = 0; k1 = 0; d1 = 0;
        v4 = 0; sop4 = 0; eop4 = 0; k4 = 0; d4 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", o1_valid, 0);
        check("rst_sum", o1_sum, 0);
        check("rst_asc", o1_asc, 0);
        check("rst_rx", o1_rx, 0);
        check("rst_match", o1_match, 0);
        check("rst_fmt", o1_fmt, 0);
        check("rst_sum4", o4_sum, 0);
        @(posedge clk); #1 rst = 0;

        send1(mk("8=A|10=183|"), 1, 1, e183);   idle(2);
        send1(mk("8=zz|10=106|"), 1, 1, e106);  idle(2);
        send1(mk("8=zz|10=107|"), 1, 1, e107);  idle(2);
        send1(mk("8=A|10=12|"), 1, 1, eerr);    idle(2);
        send1(mk("8=A|10=183"), 1, 1, eerr);    idle(2);
        send1(mk("8=A|10=1834|"), 1, 1, eerr);  idle(2);
        send1(mk("10=183|"), 1, 1, etr);        idle(2);

        send4(mk("8=A|10=183|"), -1, e183);     idle(2);
        send4(mk("8=A|10=183|"), 5, e183);      idle(2);

        // abort: the partial message has no eop, so nothing is queued for it
        send1(mk("8=A"), 1, 0, e183);
        send1(mk("8=A|10=183|"), 1, 1, e183);   idle(2);

        // back-to-back
        send1(mk("8=A|10=183|"), 1, 1, e183);
        send1(mk("8=zz|10=106|"), 1, 1, e106);  idle(2);

        // reset mid-message
        send1(mk("8=zz|10"), 1, 0, e106);
        @(posedge clk); #1;
        v1 = 0; rst = 1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_sum", o1_sum, 0);
        check("midrst_valid", o1_valid, 0);
        @(posedge clk); #1 rst = 0;
        send1(mk("8=zz|10=106|"), 1, 1, e106);  idle(4);

        check("sb_empty1", q1.size(), 0);
        check("sb_empty4", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
